// File: rtl/pipe_decoder.sv
// Registered, flow-controlled decode stage with flush and HALT hold.
// Optional undefined-instruction trap: PIPE_DECODER_ILLEGAL_TRAP_EN.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     fetch handshake; in_inst, in_pc from fetch
//   out_valid/out_ready   downstream handshake for the control bundle
//   dr, sa, sb            dest / source register addresses
//   imm, off              immediate and branch offset
//   mb, md, ld, mw        B mux, mem-to-reg, reg write, mem write
//   fs, bs                ALU function, branch select (100 = none)
//   halt, illegal         bundle is HALT / undefined instruction
//   out_pc                PC of the bundle
//   flush                 kill the held bundle
//   resume, halted        leave / report the HALTED state
module pipe_decoder #(
  parameter int RAW  = 3,
  parameter int PC_W = 16,
  localparam int INST_W = 4 + 3*RAW + 3,
  localparam int IMM_W  = RAW + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RAW-1:0]    dr,
  output logic [RAW-1:0]    sa,
  output logic [RAW-1:0]    sb,
  output logic [IMM_W-1:0]  imm,
  output logic [IMM_W-1:0]  off,
  output logic              mb,
  output logic              md,
  output logic              ld,
  output logic              mw,
  output logic [2:0]        fs,
  output logic [2:0]        bs,
  output logic              halt,
  output logic              illegal,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush,
  input  logic              resume,
  output logic              halted
);

`ifdef PIPE_DECODER_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    RUN,
    HALT_PEND,
    HALTED
  } state_t;

  typedef struct packed {
    logic [RAW-1:0]   dr;
    logic [RAW-1:0]   sa;
    logic [RAW-1:0]   sb;
    logic [IMM_W-1:0] imm;
    logic [IMM_W-1:0] off;
    logic             mb;
    logic             md;
    logic             ld;
    logic             mw;
    logic [2:0]       fs;
    logic [2:0]       bs;
    logic             halt;
    logic             illegal;
  } bundle_t;

  function automatic bundle_t nop_bundle();
    bundle_t b;
    b    = '0;
    b.bs = 3'b100;
    return b;
  endfunction

  state_t          state;
  bundle_t         dec;
  bundle_t         q;
  logic            vq;
  logic [PC_W-1:0] pc_q;
  logic            undef;
  logic            accept;

  logic [3:0]       op;
  logic [RAW-1:0]   rs;
  logic [RAW-1:0]   rt;
  logic [RAW-1:0]   rd;
  logic [2:0]       fn;
  logic [IMM_W-1:0] fimm;

  assign op   = in_inst[INST_W-1 -: 4];
  assign rs   = in_inst[INST_W-5 -: RAW];
  assign rt   = in_inst[INST_W-5-RAW -: RAW];
  assign rd   = in_inst[INST_W-5-2*RAW -: RAW];
  assign fn   = in_inst[2:0];
  assign fimm = in_inst[IMM_W-1:0];

  always_comb begin
    dec   = nop_bundle();
    undef = 1'b0;
    unique case (op)
      4'b0000: dec.halt = (fn == 3'b001);
      4'b0010: begin
        dec.dr  = rt;
        dec.sa  = rs;
        dec.imm = fimm;
        dec.mb  = 1'b1;
        dec.md  = 1'b1;
        dec.ld  = 1'b1;
      end
      4'b0100: begin
        dec.sa  = rs;
        dec.sb  = rt;
        dec.imm = fimm;
        dec.mb  = 1'b1;
        dec.mw  = 1'b1;
      end
      4'b0101, 4'b0110, 4'b0111: begin
        dec.dr  = rt;
        dec.sa  = rs;
        dec.imm = fimm;
        dec.mb  = 1'b1;
        dec.ld  = 1'b1;
        dec.fs  = op[1] ? (op[0] ? 3'b110 : 3'b101)
                        : 3'b000;
      end
      4'b1000, 4'b1001: begin
        dec.sa  = rs;
        dec.sb  = rt;
        dec.imm = fimm;
        dec.off = fimm;
        dec.fs  = 3'b001;
        dec.bs  = {2'b00, op[0]};
      end
      4'b1010, 4'b1011: begin
        dec.sa  = rs;
        dec.mb  = 1'b1;
        dec.off = fimm;
        dec.bs  = {2'b01, op[0]};
      end
      4'b1111: begin
        if (fn == 3'b111) begin
          undef = 1'b1;
        end else begin
          dec.dr  = rd;
          dec.sa  = rs;
          dec.imm = fimm;
          dec.fs  = fn;
          dec.ld  = 1'b1;
          // unary ops (010,011,100) take no B source
          if (fn == 3'b000 || fn == 3'b001 ||
              fn == 3'b101 || fn == 3'b110)
            dec.sb = rt;
        end
      end
      default: undef = 1'b1;
    endcase
    if (TRAP_EN && undef) begin
      dec         = nop_bundle();
      dec.halt    = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = (state == RUN) & ~flush
                  & (~vq | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      vq    <= 1'b0;
      q     <= nop_bundle();
      pc_q  <= '0;
    end else begin
      if (flush) begin
        vq <= 1'b0;
        if (state == HALT_PEND) state <= RUN;
      end else if (accept) begin
        vq   <= 1'b1;
        q    <= dec;
        pc_q <= in_pc;
        if (dec.halt) state <= HALT_PEND;
      end else if (out_ready) begin
        vq <= 1'b0;
        if (state == HALT_PEND && vq) state <= HALTED;
      end
      if (state == HALTED && resume) state <= RUN;
    end
  end

  assign out_valid = vq;
  assign dr        = q.dr;
  assign sa        = q.sa;
  assign sb        = q.sb;
  assign imm       = q.imm;
  assign off       = q.off;
  assign mb        = q.mb;
  assign md        = q.md;
  assign ld        = q.ld;
  assign mw        = q.mw;
  assign fs        = q.fs;
  assign bs        = q.bs;
  assign halt      = q.halt;
  assign illegal   = q.illegal;
  assign out_pc    = pc_q;
  assign halted    = (state == HALTED);

endmodule

// File: tb/tb_pipe_decoder.sv
// Scoreboard bench for pipe_decoder: random stream vs reference model.
// Also checks a RAW=4 instance with a directed R-type instruction.
module tb_pipe_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_inst, in_pc, out_pc;
  logic [2:0]  dr, sa, sb, fs, bs;
  logic [5:0]  imm, off;
  logic        mb, md, ld, mw, halt, illegal;
  logic        flush, resume, halted;

  pipe_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .dr(dr), .sa(sa), .sb(sb), .imm(imm), .off(off),
    .mb(mb), .md(md), .ld(ld), .mw(mw),
    .fs(fs), .bs(bs), .halt(halt), .illegal(illegal),
    .out_pc(out_pc), .flush(flush), .resume(resume),
    .halted(halted)
  );

  logic        w_valid, w_ready, w_ovalid, w_oready;
  logic [19:0] w_inst;
  logic [15:0] w_pc, w_opc;
  logic [3:0]  w_dr, w_sa, w_sb;
  logic [6:0]  w_imm, w_off;
  logic        w_mb, w_md, w_ld, w_mw, w_halt, w_ill;
  logic [2:0]  w_fs, w_bs;
  logic        w_flush, w_resume, w_halted;

  pipe_decoder #(.RAW(4), .PC_W(16)) u_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_valid), .in_ready(w_ready),
    .in_inst(w_inst), .in_pc(w_pc),
    .out_valid(w_ovalid), .out_ready(w_oready),
    .dr(w_dr), .sa(w_sa), .sb(w_sb),
    .imm(w_imm), .off(w_off),
    .mb(w_mb), .md(w_md), .ld(w_ld), .mw(w_mw),
    .fs(w_fs), .bs(w_bs), .halt(w_halt),
    .illegal(w_ill), .out_pc(w_opc),
    .flush(w_flush), .resume(w_resume),
    .halted(w_halted)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string n,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               n, a, e);
    end
  endtask

  // Expected control fields from the instruction-set table.
  // {dr,sa,sb,imm,off,mb,md,ld,mw,fs,bs,halt,illegal}
  function automatic logic [32:0] model(
      input logic [15:0] i);
    logic [3:0] op;
    logic [2:0] rs, rt, rd, fn;
    logic [2:0] e_dr, e_sa, e_sb, e_fs, e_bs;
    logic [5:0] im, e_imm, e_off;
    logic e_mb, e_md, e_ld, e_mw, e_h, e_il;
    op = i[15:12]; rs = i[11:9]; rt = i[8:6];
    rd = i[5:3]; fn = i[2:0]; im = i[5:0];
    e_dr = 0; e_sa = 0; e_sb = 0; e_fs = 0;
    e_bs = 3'd4; e_imm = 0; e_off = 0;
    e_mb = 0; e_md = 0; e_ld = 0; e_mw = 0;
    e_h = 0; e_il = 0;
    if (op == 4'd0) begin
      e_h = (fn == 3'd1);
    end else if (op == 4'd2) begin
      e_dr = rt; e_sa = rs; e_imm = im;
      e_mb = 1; e_md = 1; e_ld = 1;
    end else if (op == 4'd4) begin
      e_sa = rs; e_sb = rt; e_imm = im;
      e_mb = 1; e_mw = 1;
    end else if (op >= 4'd5 && op <= 4'd7) begin
      e_dr = rt; e_sa = rs; e_imm = im;
      e_mb = 1; e_ld = 1;
      e_fs = (op == 4'd5) ? 3'd0 :
             (op == 4'd6) ? 3'd5 : 3'd6;
    end else if (op == 4'd8 || op == 4'd9) begin
      e_sa = rs; e_sb = rt; e_imm = im; e_off = im;
      e_fs = 3'd1; e_bs = 3'(op - 4'd8);
    end else if (op == 4'd10 || op == 4'd11) begin
      e_sa = rs; e_mb = 1; e_off = im;
      e_bs = 3'(op - 4'd8);
    end else if (op == 4'd15 && fn != 3'd7) begin
      e_dr = rd; e_sa = rs; e_imm = im;
      e_fs = fn; e_ld = 1;
      if (fn inside {3'd0, 3'd1, 3'd5, 3'd6})
        e_sb = rt;
    end else begin
`ifdef PIPE_DECODER_ILLEGAL_TRAP_EN
      e_h = 1; e_il = 1;
`endif
    end
    return {e_dr, e_sa, e_sb, e_imm, e_off,
            e_mb, e_md, e_ld, e_mw, e_fs, e_bs,
            e_h, e_il};
  endfunction

  logic [48:0] sb_q[$];
  int ms = 0;   // 0 run, 1 halt pending, 2 halted
  bit mv = 0;   // model output-register valid

  // Handshake/state model; pushes expected bundles on accept.
  always @(negedge clk) begin : model_p
    bit er, acc;
    int cur;
    logic [32:0] e;
    if (rst_n) begin
      cur = ms;
      er = (ms == 0) && !flush && (!mv || out_ready);
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("halted", 64'(halted), 64'(ms == 2));
      acc = in_valid && er;
      if (flush) begin
        mv = 0;
        if (ms == 1) ms = 0;
      end else if (acc) begin
        e = model(in_inst);
        mv = 1;
        sb_q.push_back({e, in_pc});
        if (e[1]) ms = 1;
      end else if (out_ready) begin
        if (ms == 1 && mv) ms = 2;
        mv = 0;
      end
      if (cur == 2 && resume) ms = 0;
    end
  end

  // Monitor: compares the presented bundle with the queue head.
  always @(negedge clk) begin : mon_p
    logic [48:0] act;
    if (rst_n && out_valid) begin
      act = {dr, sa, sb, imm, off, mb, md, ld, mw,
             fs, bs, halt, illegal, out_pc};
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bundle_extra actual=%0h required=none",
                 act);
      end else begin
        chk("bundle", 64'(act), 64'(sb_q[0]));
        if (flush || out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input logic [15:0] i,
                      input logic [15:0] p, input bit r,
                      input bit f, input bit rs);
    in_valid = v; in_inst = i; in_pc = p;
    out_ready = r; flush = f; resume = rs;
    @(posedge clk); #1;
  endtask

  initial begin
    in_valid = 0; in_inst = 0; in_pc = 0;
    out_ready = 0; flush = 0; resume = 0;
    w_valid = 0; w_inst = 0; w_pc = 0; w_oready = 1;
    w_flush = 0; w_resume = 0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fields",
        64'({dr, sa, sb, imm, off, mb, md, ld, mw,
             fs, bs, halt, illegal, out_pc}),
        64'({33'd4 << 2, 16'd0}));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    step(1, 16'h5283, 16'h0100, 1, 0, 0);
    chk("addi", 64'({dr, sa, imm, mb, fs, ld, bs, out_pc}),
        64'({3'd2, 3'd1, 6'd3, 1'b1, 3'd0, 1'b1,
             3'b100, 16'h0100}));
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h2a45, 16'h0200, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      step(1, 16'h4a85, 16'h0202, 0, 0, 0);
    step(1, 16'h4a85, 16'h0202, 1, 0, 0);
    step(1, 16'hf2b5, 16'h0204, 1, 0, 0);
    step(1, 16'hb203, 16'h0206, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h9283, 16'h0300, 0, 0, 0);
    chk("bne", 64'({sa, sb, fs, bs, off, ld}),
        64'({3'd1, 3'd2, 3'd1, 3'd1, 6'd3, 1'b0}));
    step(1, 16'h5283, 16'h0302, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);

    step(1, 16'h0001, 16'h0400, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++)
      step(1, 16'h5283, 16'h0402, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(1, 16'h0001, 16'h0500, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 16'h6283, 16'h0502, 1, 0, 0);

    step(1, 16'h3000, 16'h0600, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);

    for (int k = 0; k < 3000; k++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 19) == 0) r = 16'h0001;
      step($urandom_range(0, 9) < 7, r, 16'(k),
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 3) == 0);
    end

    step(1, 16'h7283, 16'h0700, 0, 0, 0);
    #3 rst_n = 0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_halted", 64'(halted), 64'd0);
    sb_q.delete(); ms = 0; mv = 0;
    in_valid = 0;
    @(negedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    step(1, 16'h8283, 16'h0800, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    chk("w_ready", 64'(w_ready), 64'd1);
    w_inst = {4'hf, 4'd3, 4'd5, 4'd9, 3'b101};
    w_pc = 16'h0abc; w_valid = 1;
    @(posedge clk); #1;
    w_valid = 0;
    chk("width_bundle",
        64'({w_ovalid, w_dr, w_sa, w_sb, w_imm, w_off,
             w_mb, w_md, w_ld, w_mw, w_fs, w_bs,
             w_halt, w_ill, w_halted, w_opc}),
        64'({1'b1, 4'd9, 4'd3, 4'd5, 7'h4d, 7'd0,
             1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b100,
             1'b0, 1'b0, 1'b0, 16'h0abc}));

    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0);
    chk("drain", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
